clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10, is the clk cycles per 1-second tick (minimum 2).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mode_btn  input  1  single-cycle, debounced pulse that advances the mode.
REQ-005 inc_btn  input  1  single-cycle, debounced pulse that increments the field being edited.
REQ-006 stop_btn  input  1  single-cycle pulse that silences the alarm.
REQ-007 alm_en  input  1  level; 1 arms the alarm.
REQ-008 cur_sec, cur_min  input  7 each  current time from the timekeeper datapath.
REQ-009 cur_hr  input  5  current hour from the timekeeper datapath.
REQ-010 tick  output  1  one-cycle count enable to the timekeeper.
REQ-011 ld  output  1  one-cycle load strobe to the timekeeper.
REQ-012 ld_hr  output  5  hour value to load.
REQ-013 ld_min, ld_sec  output  7 each  minute and second values to load.
REQ-014 mode  output  3  current state encoding: RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4.
REQ-015 edit_hr  output  5  hour value currently being edited, for display.
REQ-016 edit_min  output  7  minute value currently being edited, for display.
REQ-017 alarm  output  1  level; 1 while the alarm is ringing.

Function
REQ-018 State sequence on mode_btn: RUN->SET_HR->SET_MIN->ALM_HR->ALM_MIN->RUN.
- No other transitions exist.
- States are held between mode_btn pulses.
REQ-019 Prescaler counts 0..TICK_DIV-1 in RUN only.
- tick=1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- In all other states the count is held at 0 and tick=0.
REQ-020 RUN->SET_HR: edit_hr<=cur_hr and edit_min<=cur_min on the transition edge.
REQ-021 SET_MIN->ALM_HR: ld=1 for exactly the first ALM_HR cycle.
- ld_hr=edit_hr, ld_min=edit_min, ld_sec=0.
- Registered alm_hr/alm_min are copied into edit_hr/edit_min on the same edge.
REQ-022 ALM_MIN->RUN: edit_hr/edit_min are written to alm_hr/alm_min; no ld pulse.
REQ-023 ld=0 in every cycle not covered by REQ-021; ld_* hold their last values.
REQ-024 inc_btn in SET_HR or ALM_HR: edit_hr increments, wrapping 23->0.
REQ-025 inc_btn in SET_MIN or ALM_MIN: edit_min increments, wrapping 59->0.
REQ-026 inc_btn in RUN is ignored.
REQ-027 mode_btn and inc_btn in the same cycle: mode advances and the increment is discarded.
REQ-028 alarm sets in RUN when all hold: alm_en=1, cur_hr==alm_hr, cur_min==alm_min, cur_sec==0, tick=1.
REQ-029 alarm clears on the next edge after any of: stop_btn=1, alm_en=0, cur_min!=alm_min, or a state other than RUN.
REQ-030 Clear takes priority over set in the same cycle.
REQ-031 Out-of-range cur_* inputs (hr>23, min/sec>59) are not checked.
- They are copied into edit_* unchanged.
- A later increment from such a value wraps to 0.
REQ-032 All outputs are registered; the only combinational output is mode, decoded from the state register.

Reset
REQ-033 rst=1 forces the following immediately, independent of clk:
- state=RUN, prescaler=0, tick=0, ld=0;
- ld_hr=0, ld_min=0, ld_sec=0;
- edit_hr=0, edit_min=0;
- alm_hr=0, alm_min=0, alarm=0.
REQ-034 Reset asserted mid-edit discards edit values without issuing ld.
REQ-035 The first tick after rst deasserts occurs TICK_DIV cycles later.

Verification
REQ-036 Tick rate: TICK_DIV=10, RUN, no buttons for 100 cycles -> exactly 10 tick pulses, 10 cycles apart, ld=0 throughout.
REQ-037 Set time: cur=13:45:xx, then mode_btn, 10x inc_btn, mode_btn, 15x inc_btn, mode_btn.
- Required: ld=1 for one cycle with ld_hr=23, ld_min=0, ld_sec=0; mode=3.
- Required: tick=0 from the first mode_btn through the end of ALM_MIN.
REQ-038 Wrap: SET_HR with edit_hr=23, inc_btn -> edit_hr=0.
- SET_MIN with edit_min=59, inc_btn -> edit_min=0.
- mode_btn and inc_btn together -> state advances, edit value unchanged.
REQ-039 Alarm: alm programmed to 06:30, alm_en=1, cur=06:30:00 on a tick -> alarm=1 next cycle.
- stop_btn -> alarm=0 next cycle.
- Repeated with alm_en=0 -> alarm stays 0.
REQ-040 Reset mid-edit: rst pulsed while in SET_MIN -> mode=0, edit_*=0, alarm=0 immediately, no ld pulse.
- The first tick follows TICK_DIV cycles after rst deasserts.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller for a digital clock with one alarm.
// It produces the 1-second tick for the timekeeper and runs the mode FSM that
// edits the time and alarm settings. A new time reaches the timekeeper through
// a one-cycle load strobe. The controller also raises the alarm when the
// current time matches the alarm setting.
module clock_set_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       stop_btn,
  input  logic       alm_en,
  input  logic [6:0] cur_sec,
  input  logic [6:0] cur_min,
  input  logic [4:0] cur_hr,
  output logic       tick,
  output logic       ld,
  output logic [4:0] ld_hr,
  output logic [6:0] ld_min,
  output logic [6:0] ld_sec,
  output logic [2:0] mode,
  output logic [4:0] edit_hr,
  output logic [6:0] edit_min,
  output logic       alarm
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4
  } state_t;

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    alm_hr;
  logic [6:0]    alm_min;

  // Anything at or above the top of the range wraps to 0. This also recovers
  // out-of-range values that were copied in from the timekeeper.
  function automatic logic [4:0] next_hr(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [6:0] next_min(input logic [6:0] m);
    return (m >= 7'd59) ? 7'd0 : m + 7'd1;
  endfunction

  assign mode = state;

  // Prescaler: runs only while in RUN and holds at 0 elsewhere. The tick is
  // registered one count early, so it is high in the cycle where the count
  // equals TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (state == RUN && !mode_btn) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples pre-edge values, whatever order the statements are in.
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == CNT_PRE);
    end else begin
      cnt  <= '0;
      tick <= 1'b0;
    end
  end

  // Mode FSM: advances on mode_btn and edits the selected field on inc_btn.
  // It also moves values between the edit, alarm and load registers on mode
  // changes. mode_btn wins over inc_btn because the increment sits in the else arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      ld       <= 1'b0;
      ld_hr    <= '0;
      ld_min   <= '0;
      ld_sec   <= '0;
      edit_hr  <= '0;
      edit_min <= '0;
      alm_hr   <= '0;
      alm_min  <= '0;
    end else begin
      // NOTE: the strobe defaults low each cycle. It is raised only on the
      // SET_MIN->ALM_HR edge, which gives a single-cycle pulse with no extra logic.
      ld <= 1'b0;
      unique case (state)
        RUN: begin
          if (mode_btn) begin
            state    <= SET_HR;
            edit_hr  <= cur_hr;
            edit_min <= cur_min;
          end
        end
        SET_HR: begin
          if (mode_btn)     state   <= SET_MIN;
          else if (inc_btn) edit_hr <= next_hr(edit_hr);
        end
        SET_MIN: begin
          if (mode_btn) begin
            state    <= ALM_HR;
            ld       <= 1'b1;
            ld_hr    <= edit_hr;
            ld_min   <= edit_min;
            ld_sec   <= '0;
            edit_hr  <= alm_hr;
            edit_min <= alm_min;
          end else if (inc_btn) begin
            edit_min <= next_min(edit_min);
          end
        end
        ALM_HR: begin
          if (mode_btn)     state   <= ALM_MIN;
          else if (inc_btn) edit_hr <= next_hr(edit_hr);
        end
        ALM_MIN: begin
          if (mode_btn) begin
            state   <= RUN;
            alm_hr  <= edit_hr;
            alm_min <= edit_min;
          end else if (inc_btn) begin
            edit_min <= next_min(edit_min);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Alarm: set on the tick that lands on hh:mm:00 of the alarm time. Any
  // clear condition overrides a coincident set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm <= 1'b0;
    end else if (stop_btn || !alm_en || cur_min != alm_min || state != RUN) begin
      alarm <= 1'b0;
    end else if (tick && cur_hr == alm_hr && cur_sec == 7'd0) begin
      alarm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl. Inputs change 1 time unit after a
// rising edge, and outputs are checked at that same point, away from the edge.
module tb_clock_set_ctrl;

  localparam int TD = 10;

  logic       clk;
  logic       rst;
  logic       mode_btn, inc_btn, stop_btn, alm_en;
  logic [6:0] cur_sec, cur_min;
  logic [4:0] cur_hr;
  logic       tick, ld, alarm;
  logic [4:0] ld_hr, edit_hr;
  logic [6:0] ld_min, ld_sec, edit_min;
  logic [2:0] mode;

  int n_checks = 0;
  int n_fail   = 0;
  int ld_count = 0;
  int edit_ticks = 0;

  clock_set_ctrl #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .stop_btn (stop_btn),
    .alm_en   (alm_en),
    .cur_sec  (cur_sec),
    .cur_min  (cur_min),
    .cur_hr   (cur_hr),
    .tick     (tick),
    .ld       (ld),
    .ld_hr    (ld_hr),
    .ld_min   (ld_min),
    .ld_sec   (ld_sec),
    .mode     (mode),
    .edit_hr  (edit_hr),
    .edit_min (edit_min),
    .alarm    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors sampled on the falling edge: ld pulses, and ticks seen outside RUN.
  always @(negedge clk) begin
    if (ld) ld_count++;
    if (tick && mode != 3'd0) edit_ticks++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      inc_btn = 1'b1;
      step();
      inc_btn = 1'b0;
    end
  endtask

  task automatic press_both();
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    step();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  // Advance until tick is high in the current cycle, with a bounded wait.
  task automatic wait_tick(input string tag);
    logic found;
    found = tick;
    for (int i = 0; i < 3 * TD && !found; i++) begin
      step();
      found = tick;
    end
    check(tag, found, 1);
  endtask

  // Count cycles from the reset release (that cycle counts as 1) up to the first tick.
  task automatic first_tick_after_release(input string tag);
    int   cyc;
    logic found;
    cyc   = 1;
    found = 1'b0;
    repeat (3 * TD) begin
      if (!found) begin
        step();
        cyc++;
        found = tick;
      end
    end
    check({tag, "_seen"}, found, 1);
    check({tag, "_cycle"}, cyc, TD);
  endtask

  initial begin
    int ticks, last, gaps_bad, ld_snap, et_snap;
    rst = 1'b1;
    mode_btn = 1'b0; inc_btn = 1'b0; stop_btn = 1'b0; alm_en = 1'b0;
    cur_hr = 5'd0; cur_min = 7'd0; cur_sec = 7'd0;

    // ---- Reset state
    step(2);
    check("rst_mode", mode, 0);
    check("rst_tick", tick, 0);
    check("rst_ld", ld, 0);
    check("rst_ld_hr", ld_hr, 0);
    check("rst_ld_min", ld_min, 0);
    check("rst_edit_hr", edit_hr, 0);
    check("rst_edit_min", edit_min, 0);
    check("rst_alarm", alarm, 0);

    // ---- First tick after release, then the tick rate over 100 cycles
    rst = 1'b0;
    first_tick_after_release("first_tick");
    ticks = 0; last = 0; gaps_bad = 0; ld_snap = ld_count;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (tick) begin
        ticks++;
        if (i - last != TD) gaps_bad++;
        last = i;
      end
    end
    check("rate_ticks", ticks, 10);
    check("rate_gaps_bad", gaps_bad, 0);
    check("rate_no_ld", ld_count - ld_snap, 0);

    // ---- Set time from 13:45 to 23:00
    et_snap = edit_ticks;
    cur_hr = 5'd13; cur_min = 7'd45; cur_sec = 7'd7;
    press_mode();
    check("set_mode_hr", mode, 1);
    check("set_copy_hr", edit_hr, 13);
    check("set_copy_min", edit_min, 45);
    press_inc(10);
    check("set_hr_23", edit_hr, 23);
    press_mode();
    check("set_mode_min", mode, 2);
    press_inc(15);
    check("set_min_wrap", edit_min, 0);
    press_mode();
    check("ld_pulse", ld, 1);
    check("ld_mode", mode, 3);
    check("ld_hr_val", ld_hr, 23);
    check("ld_min_val", ld_min, 0);
    check("ld_sec_val", ld_sec, 0);
    check("alm_copy_hr", edit_hr, 0);
    step();
    check("ld_one_cycle", ld, 0);
    check("ld_hr_hold", ld_hr, 23);

    // ---- Program the alarm to 06:30; the last press also carries inc_btn
    press_inc(6);
    press_mode();
    check("alm_mode_min", mode, 4);
    press_inc(30);
    press_both();
    check("both_to_run", mode, 0);
    check("both_min_kept", edit_min, 30);
    check("edit_no_tick", edit_ticks - et_snap, 0);

    // ---- Wrap at 23 and 59, and the combined press in SET_MIN
    cur_hr = 5'd23; cur_min = 7'd59;
    press_mode();
    press_inc(1);
    check("wrap_hr", edit_hr, 0);
    press_mode();
    press_inc(1);
    check("wrap_min", edit_min, 0);
    ld_snap = ld_count;
    press_both();
    check("both_mode3", mode, 3);
    check("both_ld", ld, 1);
    check("both_ld_min", ld_min, 0);
    check("alm_reload_hr", edit_hr, 6);
    check("alm_reload_min", edit_min, 30);
    press_both();
    check("both_mode4", mode, 4);
    check("both_hr_kept", edit_hr, 6);
    press_mode();
    press_inc(1);
    check("run_inc_ignored", edit_hr, 6);
    check("run_mode", mode, 0);

    // ---- Alarm at 06:30:00
    cur_hr = 5'd6; cur_min = 7'd30; cur_sec = 7'd0; alm_en = 1'b1;
    wait_tick("tick_a1");
    check("alarm_not_yet", alarm, 0);
    step();
    check("alarm_set", alarm, 1);
    step();
    check("alarm_hold", alarm, 1);
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    check("alarm_stop", alarm, 0);

    // stop_btn in the tick cycle: the clear wins over the set
    wait_tick("tick_a2");
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    check("alarm_clear_prio", alarm, 0);

    // A minute mismatch clears the alarm
    wait_tick("tick_a3");
    step();
    check("alarm_set2", alarm, 1);
    cur_min = 7'd31; step(); cur_min = 7'd30;
    check("alarm_min_clear", alarm, 0);

    // With alm_en low the alarm stays silent
    alm_en = 1'b0;
    wait_tick("tick_a4");
    step();
    check("alarm_disabled", alarm, 0);

    // Leaving RUN clears the alarm
    alm_en = 1'b1;
    wait_tick("tick_a5");
    step();
    check("alarm_set3", alarm, 1);
    press_mode();
    step();
    check("alarm_leave_run", alarm, 0);

    // ---- Reset mid-edit in SET_MIN
    press_mode();
    press_inc(1);
    check("pre_rst_mode", mode, 2);
    check("pre_rst_min", edit_min, 31);
    ld_snap = ld_count;
    rst = 1'b1;
    #1;
    check("mid_rst_mode", mode, 0);
    check("mid_rst_edit_hr", edit_hr, 0);
    check("mid_rst_edit_min", edit_min, 0);
    check("mid_rst_alarm", alarm, 0);
    step();
    rst = 1'b0;
    first_tick_after_release("rst_tick");
    check("rst_no_ld", ld_count - ld_snap, 0);
    // The alarm setting was cleared by reset, so ALM_HR shows 00:00
    press_mode(); press_mode(); press_mode();
    check("rst_alm_hr", edit_hr, 0);
    check("rst_alm_min", edit_min, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
